// File: rtl/life_pkg.sv
// rtl/life_pkg.sv - shared Game of Life board geometry and display scan state
package life_pkg;
    localparam int GRID_W     = 8;
    localparam int GRID_H     = 8;
    localparam int BOARD_BITS = GRID_W * GRID_H;

    typedef enum logic {
        BLANK = 1'b0,
        ON    = 1'b1
    } scan_state_t;
endpackage

// File: rtl/scan_timer.sv
// rtl/scan_timer.sv - per-state phase counter with current and next-cycle terminal strobes
module scan_timer
    import life_pkg::*;
#(
    parameter int ROW_DWELL    = 1024,
    parameter int BLANK_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  scan_state_t state,
    output logic        tc,
    output logic        tc_next
);
    localparam int            MAX_LEN    = (ROW_DWELL > BLANK_CYCLES) ? ROW_DWELL : BLANK_CYCLES;
    localparam int            PW         = $clog2(MAX_LEN + 1);
    localparam logic [PW-1:0] DWELL_LAST = PW'(ROW_DWELL - 1);
    localparam logic [PW-1:0] BLANK_LAST = PW'(BLANK_CYCLES - 1);

    logic [PW-1:0] phase;
    logic [PW-1:0] phase_n;
    scan_state_t   state_n;

    // tc_next lets the top register outputs that describe the upcoming cycle.
    always_comb begin
        tc      = (phase == ((state == ON) ? DWELL_LAST : BLANK_LAST));
        state_n = tc ? ((state == ON) ? BLANK : ON) : state;
        phase_n = tc ? '0 : phase + 1'b1;
        tc_next = (phase_n == ((state_n == ON) ? DWELL_LAST : BLANK_LAST));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase <= '0;
        end else begin
            phase <= phase_n;
        end
    end
endmodule

// File: rtl/life_matrix_scan.sv
// rtl/life_matrix_scan.sv - tear-free board buffering and row-multiplexed 8x8 LED scan
module life_matrix_scan
    import life_pkg::*;
#(
    parameter int ROW_DWELL    = 1024,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [BOARD_BITS-1:0] board_in,
    input  logic                  board_valid,
    output logic                  board_ready,
    output logic [GRID_H-1:0]     row_sel,
    output logic [GRID_W-1:0]     col_data,
    output logic                  frame_done
);
    scan_state_t           state;
    scan_state_t           state_n;
    logic [2:0]            row;
    logic [2:0]            row_n;
    logic [BOARD_BITS-1:0] shadow;
    logic [BOARD_BITS-1:0] disp;
    logic [BOARD_BITS-1:0] disp_n;
    logic                  shadow_full;
    logic                  shadow_full_n;
    logic                  tc;
    logic                  tc_next;
    logic                  frame_end;
    logic                  xfer;

    scan_timer #(
        .ROW_DWELL   (ROW_DWELL),
        .BLANK_CYCLES(BLANK_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .state  (state),
        .tc     (tc),
        .tc_next(tc_next)
    );

    always_comb begin
        xfer          = board_valid && board_ready;
        frame_end     = (state == ON) && (row == 3'd7) && tc;
        state_n       = tc ? ((state == ON) ? BLANK : ON) : state;
        row_n         = (tc && (state == ON)) ? row + 3'd1 : row;
        disp_n        = (frame_end && shadow_full) ? shadow : disp;
        shadow_full_n = shadow_full;
        if (frame_end && shadow_full) begin
            shadow_full_n = 1'b0;
        end else if (xfer) begin
            shadow_full_n = 1'b1;
        end
    end

    // Outputs are registered from next-cycle values so they line up with the scan state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= BLANK;
            row         <= 3'd0;
            shadow      <= '0;
            disp        <= '0;
            shadow_full <= 1'b0;
            board_ready <= 1'b1;
            row_sel     <= '0;
            col_data    <= '0;
            frame_done  <= 1'b0;
        end else begin
            state       <= state_n;
            row         <= row_n;
            disp        <= disp_n;
            shadow_full <= shadow_full_n;
            board_ready <= !shadow_full_n;
            if (xfer) begin
                shadow <= board_in;
            end
            row_sel    <= (state_n == ON) ? (GRID_H'(1) << row_n) : '0;
            col_data   <= (state_n == ON) ? disp_n[row_n*GRID_W +: GRID_W] : '0;
            frame_done <= (state_n == ON) && (row_n == 3'd7) && tc_next;
        end
    end
endmodule

// File: tb/tb_life_matrix_scan.sv
// tb/tb_life_matrix_scan.sv - table-driven bench for life_matrix_scan (dwell 4, blank 1)
module tb_life_matrix_scan;
    localparam int RS  = 0;
    localparam int CD  = 1;
    localparam int FD  = 2;
    localparam int RDY = 3;

    localparam logic [63:0] BRD_A = 64'h8142_2418_1824_4281;
    localparam logic [63:0] BRD_B = 64'h0102_0408_1020_4080;
    localparam logic [63:0] BRD_C = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef struct {
        int         cyc;
        int         sig;
        logic [7:0] val;
    } chk_t;

    typedef struct {
        int          cyc;
        logic        rst;
        logic        valid;
        logic [63:0] data;
    } stim_t;

    logic        clk;
    logic        rst;
    logic [63:0] board_in;
    logic        board_valid;
    logic        board_ready;
    logic [7:0]  row_sel;
    logic [7:0]  col_data;
    logic        frame_done;

    chk_t  chks[$];
    stim_t stims[$];
    int    passed;
    int    total;

    life_matrix_scan #(
        .ROW_DWELL   (4),
        .BLANK_CYCLES(1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .board_in   (board_in),
        .board_valid(board_valid),
        .board_ready(board_ready),
        .row_sel    (row_sel),
        .col_data   (col_data),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void add_chk(input int c, input int s, input logic [7:0] v);
        chk_t e;
        e.cyc = c;
        e.sig = s;
        e.val = v;
        chks.push_back(e);
    endfunction

    function automatic void add_stim(input int c, input logic r, input logic v, input logic [63:0] d);
        stim_t e;
        e.cyc   = c;
        e.rst   = r;
        e.valid = v;
        e.data  = d;
        stims.push_back(e);
    endfunction

    function automatic logic [7:0] sample(input int s);
        case (s)
            RS:      return row_sel;
            CD:      return col_data;
            FD:      return {7'd0, frame_done};
            default: return {7'd0, board_ready};
        endcase
    endfunction

    function automatic string signame(input int s);
        case (s)
            RS:      return "row_sel";
            CD:      return "col_data";
            FD:      return "frame_done";
            default: return "board_ready";
        endcase
    endfunction

    // Cycle 0 is the first cycle whose closing edge sees rst low; samples are taken at negedge.
    task automatic run_test(input string name, input int ncyc);
        rst         = 1'b1;
        board_valid = 1'b0;
        board_in    = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < ncyc; c++) begin
            foreach (chks[i]) begin
                if (chks[i].cyc == c) begin
                    logic [7:0] act;
                    act = sample(chks[i].sig);
                    total++;
                    if (act === chks[i].val) begin
                        passed++;
                    end else begin
                        $display("FAIL %s %s@%0d: got %02h want %02h",
                                 name, signame(chks[i].sig), c, act, chks[i].val);
                    end
                end
            end
            foreach (stims[i]) begin
                if (stims[i].cyc == c) begin
                    rst         = stims[i].rst;
                    board_valid = stims[i].valid;
                    board_in    = stims[i].data;
                end
            end
            @(negedge clk);
        end
        chks.delete();
        stims.delete();
    endtask

    initial begin
        passed      = 0;
        total       = 0;
        rst         = 1'b1;
        board_valid = 1'b0;
        board_in    = '0;

        // Reset idle
        add_chk(0, RS, 8'h00);  add_chk(0, CD, 8'h00);  add_chk(0, FD, 8'h00);
        add_chk(0, RDY, 8'h01); add_chk(1, RS, 8'h01);  add_chk(4, RS, 8'h01);
        add_chk(5, RS, 8'h00);  add_chk(6, RS, 8'h02);  add_chk(2, CD, 8'h00);
        add_chk(36, RS, 8'h80); add_chk(38, FD, 8'h00); add_chk(39, FD, 8'h01);
        add_chk(40, FD, 8'h00); add_chk(76, RS, 8'h80); add_chk(79, FD, 8'h01);
        run_test("idle", 81);

        // Single board
        add_stim(2, 1'b0, 1'b1, BRD_A);
        add_stim(3, 1'b0, 1'b0, '0);
        add_chk(2, RDY, 8'h01);  add_chk(3, RDY, 8'h00);  add_chk(20, RDY, 8'h00);
        add_chk(39, RDY, 8'h00); add_chk(40, RDY, 8'h01); add_chk(1, CD, 8'h00);
        add_chk(41, RS, 8'h01);  add_chk(41, CD, 8'h81);  add_chk(46, CD, 8'h42);
        add_chk(56, RS, 8'h08);  add_chk(56, CD, 8'h18);  add_chk(76, CD, 8'h81);
        run_test("single", 80);

        // Transfer exactly on the frame-end cycle
        add_stim(39, 1'b0, 1'b1, BRD_B);
        add_stim(40, 1'b0, 1'b0, '0);
        add_chk(39, RDY, 8'h01); add_chk(40, RDY, 8'h00); add_chk(41, CD, 8'h00);
        add_chk(56, CD, 8'h00);  add_chk(79, FD, 8'h01);  add_chk(79, RDY, 8'h00);
        add_chk(80, RDY, 8'h01); add_chk(81, CD, 8'h80);  add_chk(86, CD, 8'h40);
        run_test("boundary", 90);

        // Back-pressure with board_in wiggling while not ready
        add_stim(2, 1'b0, 1'b1, BRD_A);
        add_stim(3, 1'b0, 1'b1, BRD_B);
        add_stim(20, 1'b0, 1'b1, BRD_C);
        add_stim(35, 1'b0, 1'b1, BRD_B);
        add_stim(41, 1'b0, 1'b0, '0);
        add_chk(3, RDY, 8'h00);  add_chk(39, RDY, 8'h00); add_chk(40, RDY, 8'h01);
        add_chk(41, RDY, 8'h00); add_chk(41, CD, 8'h81);  add_chk(46, CD, 8'h42);
        add_chk(79, FD, 8'h01);  add_chk(80, RDY, 8'h01); add_chk(81, CD, 8'h80);
        add_chk(96, CD, 8'h10);  add_chk(121, CD, 8'h80); add_chk(121, RDY, 8'h01);
        run_test("backpressure", 125);

        // Tear check: B arrives mid-frame, frame 2 rows must all be A
        add_stim(2, 1'b0, 1'b1, BRD_A);
        add_stim(3, 1'b0, 1'b0, '0);
        add_stim(50, 1'b0, 1'b1, BRD_B);
        add_stim(51, 1'b0, 1'b0, '0);
        for (int r = 0; r < 8; r++) begin
            logic [63:0] a;
            a = BRD_A;
            add_chk(40 + 5 * r + 2, RS, 8'(1 << r));
            add_chk(40 + 5 * r + 2, CD, a[r*8 +: 8]);
        end
        add_chk(51, RDY, 8'h00); add_chk(81, CD, 8'h80);
        run_test("tear", 90);

        // Reset during row 5 ON with a board pending in the shadow
        add_stim(2, 1'b0, 1'b1, BRD_A);
        add_stim(3, 1'b0, 1'b0, '0);
        add_stim(45, 1'b0, 1'b1, BRD_B);
        add_stim(46, 1'b0, 1'b0, '0);
        add_stim(67, 1'b1, 1'b0, '0);
        add_stim(68, 1'b0, 1'b0, '0);
        add_chk(66, RS, 8'h20);   add_chk(67, CD, 8'h24);  add_chk(67, RDY, 8'h00);
        add_chk(68, RS, 8'h00);   add_chk(68, CD, 8'h00);  add_chk(68, RDY, 8'h01);
        add_chk(68, FD, 8'h00);   add_chk(69, RS, 8'h01);  add_chk(69, CD, 8'h00);
        add_chk(74, RS, 8'h02);   add_chk(107, FD, 8'h01); add_chk(108, RDY, 8'h01);
        add_chk(109, RS, 8'h01);  add_chk(109, CD, 8'h00);
        run_test("midreset", 112);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
